// File: rtl/sync_w2r_ms.sv
// Write-pointer synchronizer into the read clock domain: a SYNC_STAGES-deep flop chain with
// Gray-to-binary view, change strobe, post-reset warm-up flag and a sticky multi-bit-change monitor.
module sync_w2r_ms #(
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                rclk_i,
  input  logic                rrst_ni,
  input  logic [ADDRSIZE:0]   wptr_i,
  input  logic                err_clr_i,
  output logic [ADDRSIZE:0]   rq_wptr_o,
  output logic [ADDRSIZE:0]   rq_wbin_o,
  output logic                rq_upd_o,
  output logic                sync_vld_o,
  output logic                gray_err_o
);

  localparam int PW = ADDRSIZE + 1;
  localparam int CW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SYNC_STAGES);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $fatal(1, "sync_w2r_ms: SYNC_STAGES must be in 2..4");
  end

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when two or more bits are set (a legal Gray step flips exactly one).
  function automatic logic multi_bit(input logic [PW-1:0] d);
    return (d & (d - PW'(1))) != {PW{1'b0}};
  endfunction

  logic [PW-1:0] sync_r [SYNC_STAGES];
  logic [PW-1:0] prev_r;
  logic [CW-1:0] cnt_r;
  logic          chk_vld_r;
  logic          err_r;
  logic [PW-1:0] diff_s;
  logic          set_s;

  // Synchronizer chain: pure flop-to-flop, nothing in between.
  always_ff @(posedge rclk_i or negedge rrst_ni) begin
    if (!rrst_ni) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_r[k] <= {PW{1'b0}};
    end else begin
      sync_r[0] <= wptr_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_r[k] <= sync_r[k-1];
    end
  end

  // Previous synced sample, warm-up counter and compare-enable.
  always_ff @(posedge rclk_i or negedge rrst_ni) begin
    if (!rrst_ni) begin
      prev_r    <= {PW{1'b0}};
      cnt_r     <= {CW{1'b0}};
      chk_vld_r <= 1'b0;
    end else begin
      prev_r    <= rq_wptr_o;
      chk_vld_r <= sync_vld_o;
      if (cnt_r != CNT_MAX) cnt_r <= cnt_r + CW'(1);
      else                  cnt_r <= cnt_r;
    end
  end

  // prev_r only holds a real synced sample one cycle after the chain is flushed, so
  // comparisons are enabled from then on; the first flushed value is never a "change".
  assign diff_s = rq_wptr_o ^ prev_r;
  assign set_s  = sync_vld_o & chk_vld_r & multi_bit(diff_s);

  // Sticky Gray error flag; a new violation outranks a clear in the same cycle.
  always_ff @(posedge rclk_i or negedge rrst_ni) begin
    if (!rrst_ni) begin
      err_r <= 1'b0;
    end else if (set_s) begin
      err_r <= 1'b1;
    end else if (err_clr_i) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

  assign rq_wptr_o  = sync_r[SYNC_STAGES-1];
  assign rq_wbin_o  = gray2bin(rq_wptr_o);
  assign sync_vld_o = (cnt_r == CNT_MAX);
  assign rq_upd_o   = sync_vld_o & chk_vld_r & (diff_s != {PW{1'b0}});
  assign gray_err_o = err_r;

endmodule
